// File: rtl/mem_pkg.sv
// Shared constants for the memory responder: FSM encoding and address-field helpers.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int WORD_LSB   = $clog2(WORD_BYTES);
    localparam int CNT_W      = 4;

endpackage

// File: rtl/mem_sp_ram.sv
// Word-addressed single-port RAM; one access per enabled edge, read data registered.
// The read register only updates on an enabled read, so it holds the last read word.
module mem_sp_ram #(
    parameter int DEPTH_LOG2 = 8,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];
    logic [DATA_W-1:0] r_rdata;

    // Storage array carries no reset so it maps onto a RAM macro.
    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_en && !i_we) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts MemRead/MemWrite in IDLE, waits WAIT_CYCLES, commits, then
// pulses rdata_valid/write_done (or err for illegal requests) for one cycle; inputs ignored while busy.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              write_done,
    output logic              err
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic [DATA_W-1:0]       r_wdata;
    logic                    r_is_write;
    logic                    r_illegal;

    logic                    w_req;
    logic                    w_accept;
    logic                    w_illegal;
    logic                    w_commit;
    logic [DATA_W-1:0]       w_ram_rdata;

    assign w_req    = mem_read | mem_write;
    assign w_accept = (r_state == ST_IDLE) && w_req;

    // Any address bit above the RAM's word index makes the request out of range.
    assign w_illegal = (mem_read & mem_write)
                     | (addr[WORD_LSB-1:0] != '0)
                     | ((addr >> (DEPTH_LOG2 + WORD_LSB)) != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_state_nxt = w_illegal ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_DONE;
                    w_commit    = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_idx      <= addr[DEPTH_LOG2+WORD_LSB-1:WORD_LSB];
                r_wdata    <= wdata;
                r_is_write <= mem_write;
                r_illegal  <= w_illegal;
                r_cnt      <= w_illegal ? '0 : WAIT_INIT;
            end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // The RAM sees exactly one enabled edge per legal request: the commit edge.
    mem_sp_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_commit),
        .i_we    (r_is_write),
        .i_addr  (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign busy        = (r_state != ST_IDLE);
    assign rdata       = w_ram_rdata;
    assign err         = (r_state == ST_DONE) &&  r_illegal;
    assign write_done  = (r_state == ST_DONE) && !r_illegal &&  r_is_write;
    assign rdata_valid = (r_state == ST_DONE) && !r_illegal && !r_is_write;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: vector table, hand-built corner sequences, and random traffic
// checked against a transaction-level memory model; second instance built with WAIT_CYCLES=0.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        rd0 = 1'b0, wr0 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
    logic [31:0] ad0 = '0, wd0 = '0, ad1 = '0, wd1 = '0;
    logic        busy0, rv0, wdn0, er0, busy1, rv1, wdn1, er1;
    logic [31:0] rdt0, rdt1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: word store plus the held read-data value of each instance.
    logic [31:0] m_mem [0:255];
    logic [31:0] m_rdata [2];

    typedef struct {
        bit          r;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        int          kind;     // 0 read, 1 write, 2 error
        logic [31:0] exp_rd;   // rdata after completion
    } vec_t;

    vec_t tbl [11];

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(rd0), .mem_write(wr0), .addr(ad0), .wdata(wd0),
        .busy(busy0), .rdata(rdt0), .rdata_valid(rv0), .write_done(wdn0), .err(er0)
    );

    mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst_n(rst_n), .mem_read(rd1), .mem_write(wr1), .addr(ad1), .wdata(wd1),
        .busy(busy1), .rdata(rdt1), .rdata_valid(rv1), .write_done(wdn1), .err(er1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic set_in(input int s, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        if (s == 0) begin rd0 = r; wr0 = w; ad0 = a; wd0 = d; end
        else        begin rd1 = r; wr1 = w; ad1 = a; wd1 = d; end
    endtask

    function automatic logic [3:0] flags(input int s);
        return (s == 0) ? {busy0, rv0, wdn0, er0} : {busy1, rv1, wdn1, er1};
    endfunction

    function automatic logic [31:0] rdat(input int s);
        return (s == 0) ? rdt0 : rdt1;
    endfunction

    // Transaction-level behaviour: classify the request and apply it to the model.
    task automatic model_step(input int s, input bit r, input bit w, input logic [31:0] a,
                              input logic [31:0] d, output int kind);
        if ((r && w) || (a % 4 != 0) || (a >= 32'd1024)) begin
            kind = 2;
        end else if (w) begin
            kind = 1;
            m_mem[a / 4] = d;
        end else begin
            kind = 0;
            m_rdata[s] = m_mem[a / 4];
        end
    endtask

    // One request, strobe for a single cycle; every cycle up to one past completion is checked.
    task automatic do_req(input int s, input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input int kind, input logic [31:0] old_rd,
                          input logic [31:0] new_rd, input string nm);
        int lat;
        logic [3:0] ef;
        lat = (kind == 2) ? 1 : ((s == 0) ? 2 : 0) + 2;
        @(negedge clk);
        set_in(s, r, w, a, d);
        @(posedge clk);
        for (int n = 1; n <= lat + 1; n++) begin
            @(negedge clk);
            if (n == 1) set_in(s, 1'b0, 1'b0, a, d);
            ef = {n <= lat, (n == lat) && (kind == 0), (n == lat) && (kind == 1), (n == lat) && (kind == 2)};
            chk($sformatf("%s flags(busy,rv,wd,err) c%0d", nm, n), {28'd0, flags(s)}, {28'd0, ef});
            chk($sformatf("%s rdata c%0d", nm, n), rdat(s), (n >= lat) ? new_rd : old_rd);
        end
    endtask

    task automatic run_req(input int s, input bit r, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input string nm);
        int k;
        logic [31:0] old_rd;
        old_rd = m_rdata[s];
        model_step(s, r, w, a, d, k);
        do_req(s, r, w, a, d, k, old_rd, m_rdata[s], nm);
    endtask

    initial begin
        int k, cnt_rv, cnt_wd, cnt_er;
        logic [31:0] old_rd, ra;
        bit rr, ww;

        tbl[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        0, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 1'b1, 32'h0,   32'h00000A5A, 1, 32'hDEADBEEF};
        tbl[3]  = '{1'b1, 1'b1, 32'h0,   32'h11111111, 2, 32'hDEADBEEF};
        tbl[4]  = '{1'b1, 1'b0, 32'h13,  32'h0,        2, 32'hDEADBEEF};
        tbl[5]  = '{1'b0, 1'b1, 32'h400, 32'h22222222, 2, 32'hDEADBEEF};
        tbl[6]  = '{1'b0, 1'b1, 32'h3,   32'h33333333, 2, 32'hDEADBEEF};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,   32'h0,        0, 32'h00000A5A};
        tbl[8]  = '{1'b0, 1'b1, 32'h3FC, 32'hABCD0123, 1, 32'h00000A5A};
        tbl[9]  = '{1'b1, 1'b0, 32'h3FC, 32'h0,        0, 32'hABCD0123};
        tbl[10] = '{1'b1, 1'b0, 32'h10,  32'h0,        0, 32'hDEADBEEF};
        m_rdata[0] = '0;
        m_rdata[1] = '0;

        // Reset state
        #12;
        chk("reset flags dut", {28'd0, flags(0)}, 32'd0);
        chk("reset rdata dut", rdt0, 32'd0);
        chk("reset flags dut_w0", {28'd0, flags(1)}, 32'd0);
        chk("reset rdata dut_w0", rdt1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            old_rd = m_rdata[0];
            model_step(0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, k);
            do_req(0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].kind, old_rd,
                   tbl[i].exp_rd, $sformatf("vec%0d", i));
        end

        // Strobe held: a new access every 5 cycles
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, 32'h10, 32'h0);
        @(posedge clk);
        cnt_rv = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 20) set_in(0, 1'b0, 1'b0, 32'h0, 32'h0);
            if (rv0) cnt_rv++;
            chk($sformatf("held rv c%0d", n), {31'd0, rv0}, {31'd0, (n % 5) == 4});
        end
        chk("held pulse count", cnt_rv, 32'd4);

        // Strobes and address toggled while busy: only the original read happens
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        cnt_rv = 0; cnt_wd = 0; cnt_er = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            cnt_rv += int'(rv0); cnt_wd += int'(wdn0); cnt_er += int'(er0);
            if (n <= 3) set_in(0, 1'($urandom), 1'($urandom), $urandom, $urandom);
            else        set_in(0, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        chk("toggle rv count", cnt_rv, 32'd1);
        chk("toggle wd count", cnt_wd, 32'd0);
        chk("toggle err count", cnt_er, 32'd0);
        m_rdata[0] = m_mem[0];
        chk("toggle rdata", rdt0, m_rdata[0]);
        run_req(0, 1'b1, 1'b0, 32'h3FC, 32'h0, "toggle readback");

        // Reset during WAIT aborts the pending write
        run_req(0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, "pre-abort write");
        @(negedge clk);
        set_in(0, 1'b0, 1'b1, 32'h20, 32'h12345678);
        @(posedge clk);
        @(negedge clk);
        set_in(0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("abort busy before reset", {31'd0, busy0}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort flags in reset", {28'd0, flags(0)}, 32'd0);
        chk("abort rdata in reset", rdt0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        run_req(0, 1'b1, 1'b0, 32'h20, 32'h0, "abort readback");
        chk("abort readback value", rdt0, 32'hCAFEF00D);

        // WAIT_CYCLES=0 instance: completion 2 cycles after acceptance
        run_req(1, 1'b0, 1'b1, 32'h40, 32'h55AA33CC, "w0 write");
        run_req(1, 1'b1, 1'b0, 32'h40, 32'h0, "w0 read");
        run_req(1, 1'b1, 1'b1, 32'h40, 32'h0, "w0 err");

        // Random traffic against the model
        for (int i = 0; i < 16; i++) run_req(0, 1'b0, 1'b1, 32'(i * 4), $urandom, "init");
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 9);
            ra = 32'($urandom_range(0, 15) * 4);
            rr = 1'($urandom_range(0, 1));
            ww = !rr;
            if (k == 7) ra = ra | 32'($urandom_range(1, 3));
            if (k == 8) ra = $urandom | 32'h400;
            if (k == 9) begin rr = 1'b1; ww = 1'b1; end
            run_req(0, rr, ww, ra, $urandom, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
